// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug module: JDO field positions,
// OCI memory arbiter state encoding and requester identifiers.
package cpu_debug_pkg;

    // Bit positions inside the 38-bit JTAG data register
    localparam int JDO_WR_BIT   = 35;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_ADDR_LSB = 17;

    // Arbiter FSM: idle, or waiting one cycle for registered RAM read data
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AV_RD = 2'd1,
        JT_RD = 2'd2
    } state_e;

    // Who owned the RAM port most recently (drives the tie-break)
    typedef enum logic {
        REQ_AV = 1'b0,
        REQ_JT = 1'b1
    } req_e;

endpackage

// File: rtl/cpu_ocimem_arbiter.sv
// Single-port OCI debug RAM arbiter between the JTAG debug path and the
// CPU-side Avalon debug_mem slave. JTAG accesses use an auto-incrementing
// address; JTAG read data lands in MonDReg with monitor_ready.
module cpu_ocimem_arbiter
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_e            r_state;
    req_e              r_last_grant;
    logic              r_jt_pend;
    logic              r_jt_wr;
    logic [31:0]       r_jt_data;
    logic [ADDR_W-1:0] r_jt_addr;
    logic [31:0]       r_mon_dreg;
    logic              r_mon_ready;
    logic              r_mon_error;

    logic w_av_req;
    logic w_grant_av;
    logic w_grant_jt;
    logic w_jt_done;

    // Only the write flag, data and address fields of jdo matter here
    logic w_unused_jdo;
    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign w_av_req = av_read | av_write;

    // Grant in IDLE only; on a tie the requester not served last wins
    always_comb begin
        w_grant_av = 1'b0;
        w_grant_jt = 1'b0;
        if (r_state == IDLE) begin
            if (w_av_req && r_jt_pend) begin
                w_grant_jt = (r_last_grant == REQ_AV);
                w_grant_av = (r_last_grant == REQ_JT);
            end else begin
                w_grant_av = w_av_req;
                w_grant_jt = r_jt_pend;
            end
        end
    end

    // RAM port is driven straight from the granted requester
    always_comb begin
        ram_addr   = '0;
        ram_byteen = 4'h0;
        ram_wdata  = '0;
        ram_wren   = 1'b0;
        if (w_grant_jt) begin
            ram_addr   = r_jt_addr;
            ram_byteen = 4'hF;
            ram_wdata  = r_jt_data;
            ram_wren   = r_jt_wr;
        end else if (w_grant_av) begin
            ram_addr   = av_address;
            ram_byteen = av_byteenable;
            ram_wdata  = av_writedata;
            ram_wren   = av_write;
        end
    end

    // A JTAG access finishes on its write grant or when its read data returns
    assign w_jt_done = (w_grant_jt && r_jt_wr) || (r_state == JT_RD);

    assign av_waitrequest = !((w_grant_av && av_write) || (r_state == AV_RD));
    assign av_readdata    = ram_rdata;
    assign MonDReg        = r_mon_dreg;
    assign monitor_ready  = r_mon_ready;
    assign monitor_error  = r_mon_error;

    // FSM and tie-break history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_AV;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_av && av_read)
                        r_state <= AV_RD;
                    else if (w_grant_jt && !r_jt_wr)
                        r_state <= JT_RD;
                end
                default: r_state <= IDLE;
            endcase
            if (w_grant_av)
                r_last_grant <= REQ_AV;
            else if (w_grant_jt)
                r_last_grant <= REQ_JT;
        end
    end

    // JTAG command queue (one deep) and auto-incrementing address;
    // an address reload beats the increment of a completing access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jt_pend <= 1'b0;
            r_jt_wr   <= 1'b0;
            r_jt_data <= '0;
            r_jt_addr <= '0;
        end else begin
            if (take_action_ocimem_a)
                r_jt_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
            else if (w_jt_done)
                r_jt_addr <= r_jt_addr + ADDR_W'(1);

            if (w_jt_done)
                r_jt_pend <= 1'b0;
            if (take_action_ocimem_b && !take_action_ocimem_a && !r_jt_pend) begin
                r_jt_pend <= 1'b1;
                r_jt_wr   <= jdo[JDO_WR_BIT];
                r_jt_data <= jdo[JDO_DATA_LSB +: 32];
            end
        end
    end

    // Monitor status back to the debug slave: read data, ready, overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_dreg  <= '0;
            r_mon_ready <= 1'b0;
            r_mon_error <= 1'b0;
        end else begin
            if (r_state == JT_RD) begin
                r_mon_dreg  <= ram_rdata;
                r_mon_ready <= 1'b1;
            end else if (take_action_ocimem_a) begin
                r_mon_ready <= 1'b0;
            end

            if (take_action_ocimem_a)
                r_mon_error <= 1'b0;
            else if (take_action_ocimem_b && r_jt_pend)
                r_mon_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_ocimem_arbiter.sv
// Randomized scoreboard bench for cpu_ocimem_arbiter. The bench owns the
// OCI RAM; expected read data comes from a transaction-level memory model.
module tb_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = 4'h0;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tb_ram  [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  jt_addr_m = '0;
    logic [31:0] av_q [$];
    logic [31:0] jt_q [$];
    logic        prev_ready = 1'b0;

    cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .jdo(jdo),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    // Registered single-port RAM with byte enables
    always @(posedge clk) begin
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) tb_ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= tb_ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: pop and compare whenever the DUT presents read data
    always @(negedge clk) begin
        if (reset_n) begin
            if (av_read && !av_waitrequest) begin
                if (av_q.size() == 0) fail_now("av_unexpected_read");
                else chk("av_readdata", av_readdata, av_q.pop_front());
            end
            if (monitor_ready && !prev_ready) begin
                if (jt_q.size() == 0) fail_now("jt_unexpected_ready");
                else chk("MonDReg", MonDReg, jt_q.pop_front());
            end
        end
        prev_ready = monitor_ready;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic av_read_t(input logic [7:0] a, output int cyc);
        av_address = a;
        av_read = 1'b1;
        av_q.push_back(ref_mem[a]);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (!av_waitrequest) break;
            cyc++;
            if (cyc > 20) begin fail_now("av_read_wait"); break; end
        end
        tick(1);
        av_read = 1'b0;
    endtask

    task automatic av_write_t(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        int cyc = 0;
        av_address = a;
        av_writedata = d;
        av_byteenable = be;
        av_write = 1'b1;
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        while (1) begin
            @(negedge clk);
            if (!av_waitrequest) break;
            cyc++;
            if (cyc > 20) begin fail_now("av_write_wait"); break; end
        end
        tick(1);
        av_write = 1'b0;
    endtask

    task automatic jt_a(input logic [7:0] a);
        jdo = '0;
        jdo[24:17] = a;
        take_action_ocimem_a = 1'b1;
        jt_addr_m = a;
        tick(1);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jt_strobe_b(input logic wr, input logic [31:0] d);
        jdo = '0;
        jdo[35] = wr;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick(1);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jt_wr(input logic [31:0] d);
        ref_mem[jt_addr_m] = d;
        jt_addr_m = jt_addr_m + 8'd1;
        jt_strobe_b(1'b1, d);
    endtask

    task automatic jt_rd();
        jt_q.push_back(ref_mem[jt_addr_m]);
        jt_addr_m = jt_addr_m + 8'd1;
        jt_strobe_b(1'b0, $urandom);
    endtask

    task automatic jt_seq();
        logic [7:0] a;
        int nw;
        a = 8'h80 + 8'($urandom_range(0, 8'h70));
        jt_a(a);
        nw = $urandom_range(0, 2);
        for (int i = 0; i < nw; i++) begin
            jt_wr($urandom);
            tick(5);
        end
        if ($urandom_range(0, 1) == 1) begin
            jt_a(a + 8'($urandom_range(0, nw)));
            jt_rd();
            tick(5);
        end
    endtask

    task automatic av_seq();
        int cyc;
        tick($urandom_range(0, 3));
        repeat ($urandom_range(1, 3)) begin
            if ($urandom_range(0, 1) == 1)
                av_read_t(8'($urandom_range(0, 8'h7F)), cyc);
            else
                av_write_t(8'($urandom_range(0, 8'h7F)), $urandom, 4'($urandom_range(1, 15)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin
            tb_ram[i]  = $urandom;
            ref_mem[i] = tb_ram[i];
        end

        // Reset then idle
        tick(3);
        reset_n = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rst_waitrequest", av_waitrequest, 1);
        chk("rst_ready", monitor_ready, 0);
        chk("rst_error", monitor_error, 0);
        chk("rst_mondreg", MonDReg, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        tick(1);

        // First tie after reset: JTAG wins, Avalon waits behind one JTAG read
        jt_a(8'h20);
        jt_rd();
        av_read_t(8'h05, cyc);
        chk("tie1_av_wait", cyc, 3);
        tick(5);
        // JTAG write makes JTAG the last grantee; next tie goes to Avalon
        jt_wr(32'h1234_5678);
        tick(5);
        jt_a(8'h22);
        jt_rd();
        av_read_t(8'h06, cyc);
        chk("tie2_av_wait", cyc, 1);
        tick(5);

        // Write/read sequence with auto-increment
        jt_a(8'h10);
        jt_wr(32'hDEAD_BEEF);
        tick(5);
        jt_rd();
        tick(5);
        chk("ram_0x10", tb_ram[8'h10], 32'hDEAD_BEEF);
        jt_wr(32'hCAFE_0012);
        tick(5);
        chk("ram_0x12", tb_ram[8'h12], 32'hCAFE_0012);
        jt_a(8'h12);
        jt_rd();
        tick(5);

        // Address wraps from 0xFF to 0x00
        jt_a(8'hFF);
        jt_wr(32'hAAAA_00FF);
        tick(5);
        jt_wr(32'hBBBB_0000);
        tick(5);
        chk("wrap_ram_ff", tb_ram[8'hFF], 32'hAAAA_00FF);
        chk("wrap_ram_00", tb_ram[8'h00], 32'hBBBB_0000);

        // ocimem_a and ocimem_b together: b ignored, no error
        jdo = '0;
        jdo[35] = 1'b1;
        jdo[24:17] = 8'h30;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        jt_addr_m = 8'h30;
        tick(1);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        tick(5);
        chk("ab_same_no_error", monitor_error, 0);
        jt_rd();
        tick(5);

        // Overrun: second strobe while pending is dropped, error is sticky
        jt_a(8'h40);
        jt_rd();
        jt_strobe_b(1'b1, 32'h0BAD_0BAD);
        tick(5);
        chk("overrun_error", monitor_error, 1);
        chk("overrun_no_write", tb_ram[8'h41], ref_mem[8'h41]);
        jt_a(8'h50);
        chk("clear_error", monitor_error, 0);
        chk("clear_ready", monitor_ready, 0);

        // Randomized contention between the two requesters
        for (int it = 0; it < 60; it++) begin
            fork
                jt_seq();
                av_seq();
            join
        end
        tick(5);

        // Reset while an Avalon read is in its data cycle
        av_address = 8'h05;
        av_read = 1'b1;
        tick(1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_waitrequest", av_waitrequest, 1);
        chk("rst_mid_wren", ram_wren, 0);
        chk("rst_mid_ready", monitor_ready, 0);
        chk("rst_mid_mondreg", MonDReg, 0);
        av_read = 1'b0;
        jt_addr_m = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        av_read_t(8'h07, cyc);
        chk("post_rst_av_wait", cyc, 1);
        tick(5);

        chk("av_q_drained", av_q.size(), 0);
        chk("jt_q_drained", jt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
